// File: rtl/pong_pkg.sv
// Shared types for the pong game controller: FSM states, widths,
// ball direction and scorer encodings.
package pong_pkg;

    localparam int CW = 11;
    localparam int SW = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_x_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_y_t;

    typedef enum logic {
        SC_P1 = 1'b0,
        SC_P2 = 1'b1
    } scorer_t;

endpackage

// File: rtl/pong_ball_step.sv
// Combinational one-frame ball step: wall bounce, paddle hit
// and miss detection from pre-move position and directions.
module pong_ball_step
    import pong_pkg::*;
#(
    parameter int H_RES      = 800,
    parameter int V_RES      = 600,
    parameter int BALL_SIZE  = 8,
    parameter int PAD_W      = 8,
    parameter int P1_X       = 16,
    parameter int P2_X       = 776,
    parameter int BALL_SPEED = 4
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  dir_x_t        dx,
    input  dir_y_t        dy,
    input  logic [CW-1:0] p1_y,
    input  logic [CW-1:0] p2_y,
    input  logic [CW-1:0] pad_h,
    output logic [CW-1:0] nx,
    output logic [CW-1:0] ny,
    output dir_x_t        ndx,
    output dir_y_t        ndy,
    output logic          miss,
    output scorer_t       scorer
);

    localparam logic [11:0] SPD    = 12'(BALL_SPEED);
    localparam logic [11:0] BS     = 12'(BALL_SIZE);
    localparam logic [11:0] X_MAX  = 12'(H_RES - BALL_SIZE);
    localparam logic [11:0] Y_MAX  = 12'(V_RES - BALL_SIZE);
    localparam logic [11:0] L_EDGE = 12'(P1_X + PAD_W);
    localparam logic [11:0] R_EDGE = 12'(P2_X);
    localparam logic [11:0] R_STOP = 12'(P2_X - BALL_SIZE);

    // One extra bit keeps the edge sums from wrapping.
    logic [11:0] x12, y12, p1, p2, ph;
    logic        ov1, ov2, hit_l, hit_r;

    assign x12 = {1'b0, x};
    assign y12 = {1'b0, y};
    assign p1  = {1'b0, p1_y};
    assign p2  = {1'b0, p2_y};
    assign ph  = {1'b0, pad_h};

    assign ov1 = (y12 + BS > p1) && (y12 < p1 + ph);
    assign ov2 = (y12 + BS > p2) && (y12 < p2 + ph);

    assign hit_l = (x12 >= L_EDGE) && (x12 - SPD <= L_EDGE) && ov1;
    assign hit_r = (x12 + BS <= R_EDGE)
                && (x12 + SPD + BS >= R_EDGE) && ov2;

    always_comb begin
        nx     = x;
        ny     = y;
        ndx    = dx;
        ndy    = dy;
        miss   = 1'b0;
        scorer = SC_P1;

        if (dy == DIR_DOWN) begin
            if (y12 + SPD >= Y_MAX) begin
                ny  = Y_MAX[CW-1:0];
                ndy = DIR_UP;
            end else begin
                ny = CW'(y12 + SPD);
            end
        end else begin
            if (y12 <= SPD) begin
                ny  = '0;
                ndy = DIR_DOWN;
            end else begin
                ny = CW'(y12 - SPD);
            end
        end

        if (dx == DIR_LEFT) begin
            if (hit_l) begin
                nx  = L_EDGE[CW-1:0];
                ndx = DIR_RIGHT;
            end else if (x12 <= SPD) begin
                nx     = '0;
                miss   = 1'b1;
                scorer = SC_P2;
            end else begin
                nx = CW'(x12 - SPD);
            end
        end else begin
            if (hit_r) begin
                nx  = R_STOP[CW-1:0];
                ndx = DIR_LEFT;
            end else if (x12 + SPD >= X_MAX) begin
                nx     = X_MAX[CW-1:0];
                miss   = 1'b1;
                scorer = SC_P1;
            end else begin
                nx = CW'(x12 + SPD);
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: serve countdown, per-frame ball motion,
// scoring and game-over handling.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int H_RES        = 800,
    parameter int V_RES        = 600,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_W        = 8,
    parameter int P1_X         = 16,
    parameter int P2_X         = 776,
    parameter int PAD_H_SMALL  = 64,
    parameter int PAD_H_LARGE  = 96,
    parameter int BALL_SPEED   = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        bat_size,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [10:0] p1_y,
    input  logic [10:0] p2_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [5:0]  p1_score,
    output logic [5:0]  p2_score,
    output logic        game_over,
    output logic [2:0]  state
);

    localparam int NW = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] X_C = CW'((H_RES - BALL_SIZE) / 2);
    localparam logic [CW-1:0] Y_C = CW'((V_RES - BALL_SIZE) / 2);

    state_t        st, st_nx;
    logic [CW-1:0] bx, by, bx_nx, by_nx;
    dir_x_t        dx, dx_nx;
    dir_y_t        dy, dy_nx;
    logic [SW-1:0] s1, s2, s1_nx, s2_nx;
    logic [NW-1:0] cnt, cnt_nx;
    scorer_t       sc, sc_nx;

    logic [CW-1:0] pad_h, step_x, step_y;
    dir_x_t        step_dx;
    dir_y_t        step_dy;
    logic          step_miss;
    scorer_t       step_sc;

    assign pad_h = bat_size ? CW'(PAD_H_LARGE) : CW'(PAD_H_SMALL);

    pong_ball_step #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .BALL_SIZE  (BALL_SIZE),
        .PAD_W      (PAD_W),
        .P1_X       (P1_X),
        .P2_X       (P2_X),
        .BALL_SPEED (BALL_SPEED)
    ) u_step (
        .x      (bx),
        .y      (by),
        .dx     (dx),
        .dy     (dy),
        .p1_y   (p1_y),
        .p2_y   (p2_y),
        .pad_h  (pad_h),
        .nx     (step_x),
        .ny     (step_y),
        .ndx    (step_dx),
        .ndy    (step_dy),
        .miss   (step_miss),
        .scorer (step_sc)
    );

    always_comb begin
        st_nx  = st;
        bx_nx  = bx;
        by_nx  = by;
        dx_nx  = dx;
        dy_nx  = dy;
        s1_nx  = s1;
        s2_nx  = s2;
        cnt_nx = cnt;
        sc_nx  = sc;

        if (en) begin
            unique case (st)
                IDLE, OVER: begin
                    bx_nx = X_C;
                    by_nx = Y_C;
                    if (serve) begin
                        s1_nx  = '0;
                        s2_nx  = '0;
                        cnt_nx = '0;
                        st_nx  = SERVE;
                    end
                end
                SERVE: begin
                    bx_nx = X_C;
                    by_nx = Y_C;
                    if (frame_tick) begin
                        cnt_nx = cnt + NW'(1);
                        if (cnt == NW'(SERVE_FRAMES - 1))
                            st_nx = PLAY;
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        bx_nx = step_x;
                        by_nx = step_y;
                        dx_nx = step_dx;
                        dy_nx = step_dy;
                        if (step_miss) begin
                            sc_nx = step_sc;
                            st_nx = POINT;
                        end
                    end
                end
                POINT: begin
                    bx_nx  = X_C;
                    by_nx  = Y_C;
                    cnt_nx = '0;
                    st_nx  = SERVE;
                    // Next serve heads toward whoever just conceded.
                    if (sc == SC_P1) begin
                        s1_nx = s1 + SW'(1);
                        dx_nx = DIR_RIGHT;
                        if (s1_nx == SW'(WIN_SCORE))
                            st_nx = OVER;
                    end else begin
                        s2_nx = s2 + SW'(1);
                        dx_nx = DIR_LEFT;
                        if (s2_nx == SW'(WIN_SCORE))
                            st_nx = OVER;
                    end
                end
                default: st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= IDLE;
            bx  <= X_C;
            by  <= Y_C;
            dx  <= DIR_RIGHT;
            dy  <= DIR_DOWN;
            s1  <= '0;
            s2  <= '0;
            cnt <= '0;
            sc  <= SC_P1;
        end else begin
            st  <= st_nx;
            bx  <= bx_nx;
            by  <= by_nx;
            dx  <= dx_nx;
            dy  <= dy_nx;
            s1  <= s1_nx;
            s2  <= s2_nx;
            cnt <= cnt_nx;
            sc  <= sc_nx;
        end
    end

    assign ball_x    = bx;
    assign ball_y    = by;
    assign p1_score  = s1;
    assign p2_score  = s2;
    assign game_over = (st == OVER);
    assign state     = st;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a rule-level model predicts
// every cycle; a monitor compares on the opposite clock edge.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    localparam int H   = 800;
    localparam int V   = 600;
    localparam int BS  = 8;
    localparam int SPD = 4;
    localparam int LE  = 16 + 8;
    localparam int RE  = 776;
    localparam int SF  = 60;
    localparam int WIN = 3;
    localparam int XC  = (H - BS) / 2;
    localparam int YC  = (V - BS) / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, bat_size, frame_tick, serve;
    logic [10:0] p1_y, p2_y, ball_x, ball_y;
    logic [5:0]  p1_score, p2_score;
    logic        game_over;
    logic [2:0]  state;

    always #5 clk = ~clk;

    pong_game_ctrl #(.WIN_SCORE(WIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bat_size   (bat_size),
        .frame_tick (frame_tick),
        .serve      (serve),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .game_over  (game_over),
        .state      (state)
    );

    typedef struct {
        int x, y, s1, s2, go, st;
    } snap_t;

    snap_t q[$];
    int passed = 0;
    int total  = 0;

    // Reference model: signed velocities, plain integer geometry.
    state_t m_st;
    int mx, my, mvx, mvy, ms1, ms2, mcnt, mwho;

    task automatic model_reset();
        m_st = IDLE;
        mx = XC; my = YC;
        mvx = 1; mvy = 1;
        ms1 = 0; ms2 = 0; mcnt = 0; mwho = 0;
    endtask

    function automatic bit ov(int by, int p, int ph);
        return (by + BS > p) && (by < p + ph);
    endfunction

    task automatic play_move();
        int ph, tx, ty, ndx;
        ph  = bat_size ? 96 : 64;
        ty  = my + mvy * SPD;
        if (mvy > 0 && ty >= V - BS) begin
            ty = V - BS; mvy = -1;
        end else if (mvy < 0 && ty <= 0) begin
            ty = 0; mvy = 1;
        end
        tx  = mx + mvx * SPD;
        ndx = mvx;
        if (mvx < 0) begin
            if (mx >= LE && tx <= LE && ov(my, int'(p1_y), ph)) begin
                tx = LE; ndx = 1;
            end else if (tx <= 0) begin
                tx = 0; mwho = 2; m_st = POINT;
            end
        end else begin
            if (mx + BS <= RE && tx + BS >= RE
                && ov(my, int'(p2_y), ph)) begin
                tx = RE - BS; ndx = -1;
            end else if (tx >= H - BS) begin
                tx = H - BS; mwho = 1; m_st = POINT;
            end
        end
        mx = tx; my = ty; mvx = ndx;
    endtask

    task automatic model_step();
        if (!en) return;
        case (m_st)
            IDLE, OVER: if (serve) begin
                ms1 = 0; ms2 = 0; mcnt = 0; m_st = SERVE;
            end
            SERVE: if (frame_tick) begin
                if (mcnt == SF - 1) m_st = PLAY;
                mcnt++;
            end
            PLAY: if (frame_tick) play_move();
            POINT: begin
                if (mwho == 1) begin ms1++; mvx = 1; end
                else begin ms2++; mvx = -1; end
                mx = XC; my = YC; mcnt = 0;
                m_st = (ms1 == WIN || ms2 == WIN) ? OVER : SERVE;
            end
            default: m_st = IDLE;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            q.delete();
        end else begin
            model_step();
            q.push_back('{mx, my, ms1, ms2,
                          int'(m_st == OVER), int'(m_st)});
        end
    end

    always @(negedge clk) begin
        snap_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (e.x == int'(ball_x) && e.y == int'(ball_y)
                && e.s1 == int'(p1_score) && e.s2 == int'(p2_score)
                && e.go == int'(game_over) && e.st == int'(state))
                passed++;
            else
                $display({"FAIL scoreboard @%0t got x=%0d y=%0d s=%0d:%0d",
                          " go=%0d st=%0d expected x=%0d y=%0d s=%0d:%0d",
                          " go=%0d st=%0d"}, $time, ball_x, ball_y,
                         p1_score, p2_score, game_over, state,
                         e.x, e.y, e.s1, e.s2, e.go, e.st);
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic pulse_serve();
        @(negedge clk) serve = 1'b1;
        @(negedge clk) serve = 1'b0;
    endtask

    function automatic logic [10:0] track(int r);
        return (my >= r) ? 11'(my - r) : 11'd0;
    endfunction

    task automatic chk_reset(string tag);
        chk({tag, "_x"}, int'(ball_x), XC);
        chk({tag, "_y"}, int'(ball_y), YC);
        chk({tag, "_s1"}, int'(p1_score), 0);
        chk({tag, "_s2"}, int'(p2_score), 0);
        chk({tag, "_st"}, int'(state), int'(IDLE));
        chk({tag, "_go"}, int'(game_over), 0);
    endtask

    initial begin
        int ex, ey;
        en = 1'b1; bat_size = 1'b0;
        frame_tick = 1'b0; serve = 1'b0;
        p1_y = 11'd1000; p2_y = 11'd1000;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        pulse_serve();
        chk("serve_state", int'(state), int'(SERVE));
        repeat (SF - 1) tick();
        chk("serve_59", int'(state), int'(SERVE));
        tick();
        chk("serve_60", int'(state), int'(PLAY));
        tick();
        chk("play1_x", int'(ball_x), 400);
        chk("play1_y", int'(ball_y), 300);
        repeat (73) tick();
        chk("floor_y", int'(ball_y), 592);
        tick();
        chk("bounce_y", int'(ball_y), 588);
        for (int i = 0; i < 60 && m_st == PLAY; i++) tick();
        chk("miss_state", int'(state), int'(POINT));
        chk("miss_x", int'(ball_x), 792);
        @(negedge clk);
        chk("point_state", int'(state), int'(SERVE));
        chk("point_s1", int'(p1_score), 1);
        chk("point_x", int'(ball_x), XC);

        for (int i = 0; i < 400 && !(m_st == PLAY && mx == 764); i++) begin
            p2_y = track(20);
            tick();
        end
        p2_y = track(20);
        tick();
        chk("p2_hit_x", int'(ball_x), 768);
        p2_y = track(20);
        tick();
        chk("p2_back_x", int'(ball_x), 764);
        chk("p2_hit_s1", int'(p1_score), 1);
        chk("p2_hit_s2", int'(p2_score), 0);

        ex = mx; ey = my;
        @(negedge clk) en = 1'b0;
        repeat (10) tick();
        chk("freeze_x", int'(ball_x), ex);
        chk("freeze_y", int'(ball_y), ey);
        @(negedge clk) en = 1'b1;
        tick();
        chk("resume_x", int'(ball_x), ex - SPD);

        p2_y = 11'd1000;
        for (int i = 0; i < 3000 && m_st != OVER; i++) begin
            p1_y = track(20);
            tick();
        end
        chk("over_go", int'(game_over), 1);
        chk("over_state", int'(state), int'(OVER));
        chk("over_s1", int'(p1_score), WIN);
        chk("over_s2", int'(p2_score), 0);
        pulse_serve();
        chk("reserve_state", int'(state), int'(SERVE));
        chk("reserve_s1", int'(p1_score), 0);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        p1_y = 11'd1000;
        @(negedge clk) begin serve = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin serve = 1'b0; frame_tick = 1'b0; end
        chk("idle_serve_tick", int'(state), int'(SERVE));
        repeat (SF - 1) tick();
        chk("cnt0_59", int'(state), int'(SERVE));
        tick();
        chk("cnt0_60", int'(state), int'(PLAY));
        repeat (5) tick();
        chk("pre_rst_x", int'(ball_x), XC + 5 * SPD);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset("async");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            en         = ($urandom_range(0, 19) != 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            serve      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 499) == 0) bat_size = ~bat_size;
            p1_y = ($urandom_range(0, 3) != 0) ?
                   track($urandom_range(0, 80)) : 11'($urandom_range(0, 700));
            p2_y = ($urandom_range(0, 3) != 0) ?
                   track($urandom_range(0, 80)) : 11'($urandom_range(0, 700));
        end
        frame_tick = 1'b0; serve = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
